slave_regbank: RTL and testbench
================================

SLAVE_REGBANK -- requirements
Module: slave_regbank

Interface
REQ-001 Parameter DATA_W, default 32: register and bus data width; multiple of 8, range 8..64.
REQ-002 Parameter N_OUT, default 16: number of host-writable output registers; range 1..128.
REQ-003 Parameter N_IN, default 16: number of host-readable input registers; range 1..128.
REQ-004 Parameter ADDR_W, default 9: word-address width; fixed at 9 by the address map.
REQ-005 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port slave_address, input, ADDR_W bits: word address.
REQ-008 Port slave_read, input, 1 bit: read request.
REQ-009 Port slave_write, input, 1 bit: write request.
REQ-010 Port slave_writedata, input, DATA_W bits: write data.
REQ-011 Port slave_byteenable, input, DATA_W/8 bits: per-byte write enables.
REQ-012 Port slave_readdata, output, DATA_W bits: read data, registered.
REQ-013 Port slave_readdatavalid, output, 1 bit: slave_readdata is valid this cycle.
REQ-014 Port user_dataout, output, N_OUT*DATA_W bits: output register i occupies bits [i*DATA_W +: DATA_W].
REQ-015 Port user_dataout_wr, output, N_OUT bits: one-cycle pulse per output register written.
REQ-016 Port user_datain, input, N_IN*DATA_W bits: input channel j occupies bits [j*DATA_W +: DATA_W].
REQ-017 Port irq, output, 1 bit: level interrupt, registered.

Function
REQ-018 The address map SHALL be: 0..N_OUT-1 OUT[i] (RW); 128..128+N_IN-1 IN[j] (RO); 256 STATUS (W1C, bit j = change on IN[j]); 257 MASK (RW); 258 ID (RO, {N_IN[15:0], N_OUT[15:0]} truncated to DATA_W).
REQ-019 A write SHALL update only the bytes whose slave_byteenable bit is 1; this applies to OUT, MASK and the W1C bytes of STATUS.
REQ-020 A write to OUT[i] SHALL take effect on user_dataout in the next cycle, with user_dataout_wr[i]=1 for exactly that cycle, including when all byteenables are 0.
REQ-021 A read SHALL produce slave_readdata and slave_readdatavalid=1 exactly one cycle after slave_read; reads are fully pipelined, one per cycle.
REQ-022 A read and a write to the same OUT register in the same cycle SHALL return the pre-write value.
REQ-023 If slave_read and slave_write are both asserted, the write SHALL be performed and the read ignored (no slave_readdatavalid).
REQ-024 A read of an unmapped address SHALL return 0 with valid asserted; a write to an unmapped or RO address SHALL be ignored.
REQ-025 user_datain SHALL be sampled into IN_Q every cycle, and IN_Q is held in a second register IN_P; host reads of IN[j] SHALL return IN_Q[j].
REQ-026 STATUS[j] SHALL be set in the cycle after IN_Q[j] != IN_P[j], and SHALL be cleared by writing 1 to it; if set and clear occur in the same cycle, set wins.
REQ-027 irq SHALL equal the registered OR of (STATUS & MASK), i.e. it lags a STATUS change by one cycle.
REQ-028 STATUS and MASK SHALL be N_IN bits wide, zero-extended on read; writes to bits at or above N_IN SHALL be ignored.
REQ-029 slave_readdata SHALL hold its last value while slave_readdatavalid=0.

Reset
REQ-030 While reset=1, all of the following SHALL be 0 on the next edge: OUT[*], MASK, STATUS, IN_Q, IN_P, user_dataout_wr, slave_readdata, slave_readdatavalid and irq.
REQ-031 A read or write issued while reset=1 SHALL be discarded, and a read in flight when reset asserts SHALL NOT produce slave_readdatavalid.
REQ-032 In the first cycle after reset deasserts, a nonzero user_datain SHALL NOT set STATUS, because IN_P is loaded together with IN_Q on that cycle.

Structure
REQ-033 A shared package slave_regbank_pkg SHALL hold the address-map constants (OUT_BASE=0, IN_BASE=128, STATUS_ADDR=256, MASK_ADDR=257, ID_ADDR=258) and a byte-enable-merge function.
REQ-034 A single sub-module regbank_chgdet SHALL implement the IN_Q/IN_P sampling, STATUS set/clear logic and irq; decode and readback mux stay in the top module.

Verification
REQ-035 Bench: write OUT[3]=0xDEADBEEF with byteenable=0xF, then 0x00000011 with byteenable=0x1 -> user_dataout slice 3 = 0xDEADBE11, and user_dataout_wr[3] pulses once per write.
REQ-036 Bench: read addresses 0, 129, 258 back-to-back -> three consecutive valid cycles returning OUT[0], IN[1], and 0x00100010 (defaults).
REQ-037 Bench: MASK=0x0004, toggle user_datain channel 2 -> STATUS=0x0004 after 2 cycles and irq=1 after 3; writing STATUS=0x0004 drops irq.
REQ-038 Bench: change channel 2 in the same cycle STATUS bit 2 is written 1 -> STATUS bit 2 remains 1.
REQ-039 Bench: assert read and write to OUT[0] together -> OUT[0] is updated and no readdatavalid occurs; assert reset mid-stream -> all outputs read 0 and no stray valid.
REQ-040 Bench: with N_OUT=4, N_IN=2, DATA_W=16, read 258 -> 0x0004 and read 130 -> 0.

Source files
------------

// File: rtl/slave_regbank_pkg.sv
// Shared address map and byte-enable merge helper for the slave register bank.
package slave_regbank_pkg;

  localparam int unsigned OUT_BASE    = 0;
  localparam int unsigned IN_BASE     = 128;
  localparam int unsigned STATUS_ADDR = 256;
  localparam int unsigned MASK_ADDR   = 257;
  localparam int unsigned ID_ADDR     = 258;

  // Widest supported bus; callers cast to and from their own width.
  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_BE = MAX_DW / 8;

  // Replace the bytes of old_val selected by be with the bytes of new_val.
  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_val,
                                                 input logic [MAX_DW-1:0] new_val,
                                                 input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(MAX_BE); b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/slave_regbank_chgdet.sv
// Input sampling, change detection into STATUS (W1C, set wins) and registered irq.
module regbank_chgdet
  import slave_regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_IN   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN*DATA_W-1:0]   i_datain,
  input  logic [N_IN-1:0]          i_clr,
  input  logic [N_IN-1:0]          i_mask,
  output logic [N_IN*DATA_W-1:0]   o_in_q,
  output logic [N_IN-1:0]          o_status,
  output logic                     o_irq
);

  logic [N_IN*DATA_W-1:0] r_in_q;
  logic [N_IN*DATA_W-1:0] r_in_p;
  logic [N_IN-1:0]        r_status;
  logic                   r_first;
  logic                   r_irq;
  logic [N_IN-1:0]        w_chg;

  // Per-channel difference between the current and previous sample.
  always_comb begin
    w_chg = '0;
    for (int j = 0; j < int'(N_IN); j++) begin
      w_chg[j] = (r_in_q[j*DATA_W +: DATA_W] != r_in_p[j*DATA_W +: DATA_W]);
    end
  end

  // Sample pipeline; on the first cycle out of reset both stages load the input
  // so a nonzero idle value is not mistaken for a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_q   <= '0;
      r_in_p   <= '0;
      r_status <= '0;
      r_first  <= 1'b1;
      r_irq    <= 1'b0;
    end else begin
      r_in_q   <= i_datain;
      r_in_p   <= r_first ? i_datain : r_in_q;
      r_first  <= 1'b0;
      r_status <= (r_status & ~i_clr) | w_chg;
      r_irq    <= |(r_status & i_mask);
    end
  end

  assign o_in_q   = r_in_q;
  assign o_status = r_status;
  assign o_irq    = r_irq;

endmodule

// File: rtl/slave_regbank.sv
// Host-facing register bank: output registers, sampled inputs, STATUS/MASK/ID.
module slave_regbank
  import slave_regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_OUT  = 16,
  parameter int unsigned N_IN   = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        slave_address,
  input  logic                     slave_read,
  input  logic                     slave_write,
  input  logic [DATA_W-1:0]        slave_writedata,
  input  logic [DATA_W/8-1:0]      slave_byteenable,
  output logic [DATA_W-1:0]        slave_readdata,
  output logic                     slave_readdatavalid,
  output logic [N_OUT*DATA_W-1:0]  user_dataout,
  output logic [N_OUT-1:0]         user_dataout_wr,
  input  logic [N_IN*DATA_W-1:0]   user_datain,
  output logic                     irq
);

  localparam int unsigned SW     = (N_IN < DATA_W) ? N_IN : DATA_W;
  localparam logic [31:0] ID_VAL = {16'(N_IN), 16'(N_OUT)};

  logic [DATA_W-1:0]       r_out [N_OUT];
  logic [N_OUT-1:0]        r_wr;
  logic [N_IN-1:0]         r_mask;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_rvalid;

  logic                    w_rd;
  logic [DATA_W-1:0]       w_rdata;
  logic [DATA_W-1:0]       w_be_data;
  logic [DATA_W-1:0]       w_mask_merged;
  logic [N_IN-1:0]         w_mask_next;
  logic [N_IN-1:0]         w_clr;
  logic [N_IN-1:0]         w_status;
  logic [N_IN*DATA_W-1:0]  w_in_q;
  logic                    w_irq;

  // A simultaneous write wins; the read is dropped.
  assign w_rd = slave_read & ~slave_write;

  // Write data with disabled bytes forced to zero (W1C clear pattern).
  assign w_be_data = DATA_W'(be_merge('0, MAX_DW'(slave_writedata), MAX_BE'(slave_byteenable)));
  assign w_clr     = (slave_write && (slave_address == ADDR_W'(STATUS_ADDR))) ? N_IN'(w_be_data) : '0;

  // MASK merge: only bits below both N_IN and DATA_W are host-writable.
  always_comb begin
    w_mask_merged = DATA_W'(be_merge(MAX_DW'(DATA_W'(r_mask)), MAX_DW'(slave_writedata),
                                     MAX_BE'(slave_byteenable)));
    w_mask_next          = r_mask;
    w_mask_next[SW-1:0]  = SW'(w_mask_merged);
  end

  // Readback mux; unmapped addresses read as zero.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      if (slave_address == ADDR_W'(OUT_BASE + i)) w_rdata = r_out[i];
    end
    for (int j = 0; j < int'(N_IN); j++) begin
      if (slave_address == ADDR_W'(IN_BASE + j)) w_rdata = w_in_q[j*DATA_W +: DATA_W];
    end
    if (slave_address == ADDR_W'(STATUS_ADDR)) w_rdata = DATA_W'(w_status);
    if (slave_address == ADDR_W'(MASK_ADDR))   w_rdata = DATA_W'(r_mask);
    if (slave_address == ADDR_W'(ID_ADDR))     w_rdata = DATA_W'(ID_VAL);
  end

  // Output registers with byte-enable merge and one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_OUT); i++) r_out[i] <= '0;
      r_wr <= '0;
    end else begin
      r_wr <= '0;
      for (int i = 0; i < int'(N_OUT); i++) begin
        if (slave_write && (slave_address == ADDR_W'(OUT_BASE + i))) begin
          r_out[i] <= DATA_W'(be_merge(MAX_DW'(r_out[i]), MAX_DW'(slave_writedata),
                                       MAX_BE'(slave_byteenable)));
          r_wr[i]  <= 1'b1;
        end
      end
    end
  end

  // MASK register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (slave_write && (slave_address == ADDR_W'(MASK_ADDR))) begin
      r_mask <= w_mask_next;
    end
  end

  // Registered read response; data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  regbank_chgdet #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN)
  ) u_chgdet (
    .clk      (clk),
    .reset    (reset),
    .i_datain (user_datain),
    .i_clr    (w_clr),
    .i_mask   (r_mask),
    .o_in_q   (w_in_q),
    .o_status (w_status),
    .o_irq    (w_irq)
  );

  for (genvar gi = 0; gi < int'(N_OUT); gi++) begin : g_out
    assign user_dataout[gi*DATA_W +: DATA_W] = r_out[gi];
  end

  assign user_dataout_wr     = r_wr;
  assign slave_readdata      = r_rdata;
  assign slave_readdatavalid = r_rvalid;
  assign irq                 = w_irq;

endmodule

// File: tb/tb_slave_regbank.sv
// Self-checking bench for slave_regbank against a behavioural register-map model.
module tb_slave_regbank;

  logic         clk = 1'b0;
  logic         reset;
  logic [8:0]   slave_address;
  logic         slave_read;
  logic         slave_write;
  logic [31:0]  slave_writedata;
  logic [3:0]   slave_byteenable;
  logic [31:0]  slave_readdata;
  logic         slave_readdatavalid;
  logic [511:0] user_dataout;
  logic [15:0]  user_dataout_wr;
  logic [511:0] user_datain;
  logic         irq;

  // Small configuration instance
  logic [8:0]   s_addr;
  logic         s_rd;
  logic [15:0]  s_rdata;
  logic         s_rdv;
  logic [63:0]  s_dataout;
  logic [3:0]   s_dataout_wr;
  logic         s_irq;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic [31:0]  m_out [16];
  logic [15:0]  m_mask, m_status, m_wrp;
  logic [511:0] m_last, m_prev;
  logic         m_first, m_valid, m_irq;
  logic [31:0]  m_rdata;

  always #5 clk = ~clk;

  slave_regbank dut (
    .clk(clk), .reset(reset), .slave_address(slave_address), .slave_read(slave_read),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable), .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid), .user_dataout(user_dataout),
    .user_dataout_wr(user_dataout_wr), .user_datain(user_datain), .irq(irq)
  );

  slave_regbank #(.DATA_W(16), .N_OUT(4), .N_IN(2), .ADDR_W(9)) u_small (
    .clk(clk), .reset(reset), .slave_address(s_addr), .slave_read(s_rd),
    .slave_write(1'b0), .slave_writedata(16'h0), .slave_byteenable(2'b00),
    .slave_readdata(s_rdata), .slave_readdatavalid(s_rdv), .user_dataout(s_dataout),
    .user_dataout_wr(s_dataout_wr), .user_datain(32'h1234_5678), .irq(s_irq)
  );

  function automatic logic [31:0] m_read(input logic [8:0] a);
    int ai;
    ai = int'(a);
    if (ai < 16) return m_out[ai];
    if (ai >= 128 && ai < 144) return m_last[32*(ai-128) +: 32];
    if (ai == 256) return {16'h0, m_status};
    if (ai == 257) return {16'h0, m_mask};
    if (ai == 258) return 32'h0010_0010;
    return 32'h0;
  endfunction

  // Register-map semantics applied at one clock edge using the inputs present there.
  task automatic model_edge();
    logic [31:0] bm;
    logic [15:0] chg, clr;
    int ai;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_out[i] = '0;
      m_mask = '0; m_status = '0; m_wrp = '0; m_last = '0; m_prev = '0;
      m_first = 1'b1; m_valid = 1'b0; m_irq = 1'b0; m_rdata = '0;
    end else begin
      ai = int'(slave_address);
      bm = {{8{slave_byteenable[3]}}, {8{slave_byteenable[2]}},
            {8{slave_byteenable[1]}}, {8{slave_byteenable[0]}}};
      chg = '0;
      for (int j = 0; j < 16; j++) chg[j] = (m_last[32*j +: 32] != m_prev[32*j +: 32]);
      m_irq = |(m_status & m_mask);
      m_wrp = '0;
      clr   = '0;
      if (slave_read && !slave_write) begin
        m_valid = 1'b1;
        m_rdata = m_read(slave_address);
      end else begin
        m_valid = 1'b0;
      end
      if (slave_write) begin
        if (ai < 16) begin
          m_out[ai] = (m_out[ai] & ~bm) | (slave_writedata & bm);
          m_wrp[ai] = 1'b1;
        end else if (ai == 257) begin
          m_mask = (m_mask & ~bm[15:0]) | (slave_writedata[15:0] & bm[15:0]);
        end else if (ai == 256) begin
          clr = slave_writedata[15:0] & bm[15:0];
        end
      end
      m_status = (m_status & ~clr) | chg;
      m_prev   = m_first ? user_datain : m_last;
      m_last   = user_datain;
      m_first  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    slave_read = 1'b0; slave_write = 1'b0;
    slave_address = '0; slave_writedata = '0; slave_byteenable = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    slave_read = 1'b1; slave_write = 1'b1; slave_address = 9'd1;
    slave_writedata = 32'hFFFF_FFFF; slave_byteenable = 4'hF;
    user_datain = {16{32'hA5A5_0001}};
    s_addr = '0; s_rd = 1'b0;
    tick(); tick();
    n_vec++;
    if (user_dataout !== '0 || user_dataout_wr !== '0) begin
      n_miss++; $display("FAIL reset_out: dataout=%h wr=%h expected 0", user_dataout, user_dataout_wr);
    end
    n_vec++;
    if (slave_readdatavalid !== 1'b0 || slave_readdata !== '0 || irq !== 1'b0) begin
      n_miss++; $display("FAIL reset_rd: rdv=%b rdata=%h irq=%b expected 0", slave_readdatavalid, slave_readdata, irq);
    end
    reset = 1'b0;
    idle();
    tick(); tick(); tick();
    slave_read = 1'b1; slave_address = 9'd256;
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h0) begin
      n_miss++; $display("FAIL status_after_reset: rdv=%b status=%h expected 1/00000000", slave_readdatavalid, slave_readdata);
    end
    idle();
    tick();
  endtask

  task automatic test_byteenable();
    slave_write = 1'b1; slave_address = 9'd3; slave_writedata = 32'hDEAD_BEEF; slave_byteenable = 4'hF;
    tick();
    idle();
    n_vec++;
    if (user_dataout[96 +: 32] !== 32'hDEAD_BEEF || user_dataout_wr !== 16'h0008) begin
      n_miss++; $display("FAIL be_full: out3=%h wr=%h expected deadbeef/0008", user_dataout[96 +: 32], user_dataout_wr);
    end
    tick();
    n_vec++;
    if (user_dataout_wr !== 16'h0) begin
      n_miss++; $display("FAIL wr_pulse_end: wr=%h expected 0000", user_dataout_wr);
    end
    slave_write = 1'b1; slave_address = 9'd3; slave_writedata = 32'h0000_0011; slave_byteenable = 4'h1;
    tick();
    idle();
    n_vec++;
    if (user_dataout[96 +: 32] !== 32'hDEAD_BE11 || user_dataout_wr !== 16'h0008) begin
      n_miss++; $display("FAIL be_byte0: out3=%h wr=%h expected deadbe11/0008", user_dataout[96 +: 32], user_dataout_wr);
    end
    slave_write = 1'b1; slave_address = 9'd3; slave_writedata = 32'h1234_5678; slave_byteenable = 4'h0;
    tick();
    idle();
    n_vec++;
    if (user_dataout[96 +: 32] !== 32'hDEAD_BE11 || user_dataout_wr !== 16'h0008) begin
      n_miss++; $display("FAIL be_none: out3=%h wr=%h expected deadbe11/0008", user_dataout[96 +: 32], user_dataout_wr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v0, v1;
    v0 = $urandom; v1 = $urandom;
    slave_write = 1'b1; slave_address = 9'd0; slave_writedata = v0; slave_byteenable = 4'hF;
    user_datain[32 +: 32] = v1;
    tick();
    idle();
    tick(); tick();
    slave_read = 1'b1; slave_address = 9'd0;
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b1 || slave_readdata !== v0) begin
      n_miss++; $display("FAIL b2b_out0: rdv=%b data=%h expected 1/%h", slave_readdatavalid, slave_readdata, v0);
    end
    slave_address = 9'd129;
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b1 || slave_readdata !== v1) begin
      n_miss++; $display("FAIL b2b_in1: rdv=%b data=%h expected 1/%h", slave_readdatavalid, slave_readdata, v1);
    end
    slave_address = 9'd258;
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h0010_0010) begin
      n_miss++; $display("FAIL b2b_id: rdv=%b data=%h expected 1/00100010", slave_readdatavalid, slave_readdata);
    end
    idle();
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b0 || slave_readdata !== 32'h0010_0010) begin
      n_miss++; $display("FAIL rdata_hold: rdv=%b data=%h expected 0/00100010", slave_readdatavalid, slave_readdata);
    end
    // clear any STATUS bits from the channel-1 change
    slave_write = 1'b1; slave_address = 9'd256; slave_writedata = 32'hFFFF; slave_byteenable = 4'hF;
    tick();
    idle();
  endtask

  task automatic test_irq();
    slave_write = 1'b1; slave_address = 9'd257; slave_writedata = 32'h0004; slave_byteenable = 4'hF;
    tick();
    slave_address = 9'd256; slave_writedata = 32'hFFFF;
    tick();
    idle();
    user_datain[64 +: 32] = ~user_datain[64 +: 32];
    tick();
    tick();
    n_vec++;
    if (irq !== 1'b0) begin
      n_miss++; $display("FAIL irq_early: irq=%b expected 0", irq);
    end
    slave_read = 1'b1; slave_address = 9'd256;
    tick();
    idle();
    n_vec++;
    if (slave_readdata !== 32'h0004 || irq !== 1'b1) begin
      n_miss++; $display("FAIL status_irq: status=%h irq=%b expected 00000004/1", slave_readdata, irq);
    end
    slave_write = 1'b1; slave_address = 9'd256; slave_writedata = 32'h0004; slave_byteenable = 4'hF;
    tick();
    idle();
    tick();
    n_vec++;
    if (irq !== 1'b0) begin
      n_miss++; $display("FAIL irq_clear: irq=%b expected 0", irq);
    end
  endtask

  task automatic test_set_wins();
    user_datain[64 +: 32] = ~user_datain[64 +: 32];
    tick();
    user_datain[64 +: 32] = user_datain[64 +: 32] + 32'd1;
    tick();
    slave_write = 1'b1; slave_address = 9'd256; slave_writedata = 32'h0004; slave_byteenable = 4'hF;
    tick();
    idle();
    slave_read = 1'b1; slave_address = 9'd256;
    tick();
    idle();
    n_vec++;
    if (slave_readdata[2] !== 1'b1 || slave_readdata !== m_rdata) begin
      n_miss++; $display("FAIL set_wins: status=%h expected bit2 set, model %h", slave_readdata, m_rdata);
    end
    slave_write = 1'b1; slave_address = 9'd256; slave_writedata = 32'hFFFF; slave_byteenable = 4'hF;
    tick();
    idle();
  endtask

  task automatic test_collide_and_reset();
    logic [31:0] v;
    v = $urandom;
    slave_read = 1'b1; slave_write = 1'b1; slave_address = 9'd0; slave_writedata = v; slave_byteenable = 4'hF;
    tick();
    idle();
    n_vec++;
    if (slave_readdatavalid !== 1'b0 || user_dataout[31:0] !== v) begin
      n_miss++; $display("FAIL rw_collide: rdv=%b out0=%h expected 0/%h", slave_readdatavalid, user_dataout[31:0], v);
    end
    slave_read = 1'b1; slave_address = 9'd0;
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b0 || slave_readdata !== '0 || user_dataout !== '0 || irq !== 1'b0) begin
      n_miss++; $display("FAIL mid_reset: rdv=%b rdata=%h out=%h irq=%b expected all 0", slave_readdatavalid, slave_readdata, user_dataout, irq);
    end
    reset = 1'b0;
    idle();
    tick();
    n_vec++;
    if (slave_readdatavalid !== 1'b0) begin
      n_miss++; $display("FAIL stray_valid: rdv=%b expected 0", slave_readdatavalid);
    end
    slave_read = 1'b1; slave_address = 9'd0;
    tick();
    idle();
    n_vec++;
    if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h0) begin
      n_miss++; $display("FAIL out0_after_reset: rdv=%b data=%h expected 1/0", slave_readdatavalid, slave_readdata);
    end
  endtask

  task automatic test_random();
    logic [8:0] a;
    int sel;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: a = 9'($urandom_range(0, 17));
        1: a = 9'($urandom_range(126, 145));
        2: a = 9'($urandom_range(255, 259));
        default: a = 9'($urandom);
      endcase
      slave_address    = a;
      slave_read       = ($urandom_range(0, 2) != 0);
      slave_write      = ($urandom_range(0, 2) == 0);
      slave_writedata  = $urandom;
      slave_byteenable = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 15));
        user_datain[32*sel +: 32] = user_datain[32*sel +: 32] ^ (32'h1 << $urandom_range(0, 31));
      end
      tick();
      n_vec++;
      for (int i = 0; i < 16; i++) begin
        if (user_dataout[32*i +: 32] !== m_out[i]) begin
          n_miss++; $display("FAIL rnd_out%0d cyc %0d: got %h expected %h", i, c, user_dataout[32*i +: 32], m_out[i]);
        end
      end
      if (user_dataout_wr !== m_wrp) begin
        n_miss++; $display("FAIL rnd_wr cyc %0d: got %h expected %h", c, user_dataout_wr, m_wrp);
      end
      if (slave_readdatavalid !== m_valid || slave_readdata !== m_rdata) begin
        n_miss++; $display("FAIL rnd_rd cyc %0d: got %b/%h expected %b/%h", c, slave_readdatavalid, slave_readdata, m_valid, m_rdata);
      end
      if (irq !== m_irq) begin
        n_miss++; $display("FAIL rnd_irq cyc %0d: got %b expected %b", c, irq, m_irq);
      end
    end
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_small();
    s_rd = 1'b1; s_addr = 9'd258;
    tick();
    n_vec++;
    if (s_rdv !== 1'b1 || s_rdata !== 16'h0004) begin
      n_miss++; $display("FAIL small_id: rdv=%b data=%h expected 1/0004", s_rdv, s_rdata);
    end
    s_addr = 9'd130;
    tick();
    n_vec++;
    if (s_rdv !== 1'b1 || s_rdata !== 16'h0000) begin
      n_miss++; $display("FAIL small_unmapped: rdv=%b data=%h expected 1/0000", s_rdv, s_rdata);
    end
    s_rd = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_byteenable();
    test_back_to_back();
    test_irq();
    test_set_wins();
    test_collide_and_reset();
    test_random();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
